spi_txn_sequencer: RTL

Byte-stream sequencer that sits directly upstream of the SPI byte driver. It accepts multi-byte transactions from a host over a valid/ready stream and buffers them in a TX FIFO. It feeds the driver one byte at a time (data plus a one-cycle start pulse), waits for each byte to complete, and returns every received byte with its framing bit through an RX FIFO.

---
 rtl/spi_txn_sequencer_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 66 ++++++
 rtl/spi_txn_sequencer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/spi_txn_sequencer_pkg.sv
// Shared types and widths for the SPI transaction sequencer.
// Entries carry the transaction-final flag above the data byte.
package spi_seq_pkg;

    localparam int BYTE_W  = 8;
    localparam int ENTRY_W = BYTE_W + 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        CAPTURE   = 3'd4
    } seq_state_t;

    function automatic logic [ENTRY_W-1:0] pack_entry(input logic last, input logic [BYTE_W-1:0] data);
        return {last, data};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered occupancy count.
// Pointers wrap naturally because DEPTH is a power of two.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_s;
    logic             pop_s;

    assign full    = (count_r == CNT_W'(DEPTH));
    assign empty   = (count_r == {CNT_W{1'b0}});
    assign count   = count_r;
    assign rd_data = mem_r[rd_ptr_r];
    assign push_s  = push && !full;
    assign pop_s   = pop && !empty;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage, cleared so the head reads zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

endmodule

// File: rtl/spi_txn_sequencer.sv
// Feeds buffered host bytes to the SPI byte driver one at a time and
// returns each received byte, tagged with its framing bit, through an RX FIFO.
module spi_txn_sequencer
    import spi_seq_pkg::*;
#(
    parameter int FIFO_DEPTH    = 8,
    parameter int START_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [BYTE_W-1:0] tx_data,
    input  logic              tx_last,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_last,
    output logic [BYTE_W-1:0] drv_data_in,
    output logic              drv_start,
    input  logic              drv_busy,
    input  logic [BYTE_W-1:0] drv_data_out,
    output logic              txn_active,
    output logic              err_timeout,
    input  logic              err_clr
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int TO_W  = $clog2(START_TIMEOUT + 1);

    seq_state_t         state_r;
    logic               cur_last_r;
    logic [TO_W-1:0]    to_cnt_r;

    logic [ENTRY_W-1:0] tx_wr_s;
    logic [ENTRY_W-1:0] tx_rd_s;
    logic               tx_push_s;
    logic               tx_pop_s;
    logic               tx_full_s;
    logic               tx_empty_s;
    logic [CNT_W-1:0]   tx_count_s;

    logic [ENTRY_W-1:0] rx_wr_s;
    logic [ENTRY_W-1:0] rx_rd_s;
    logic               rx_push_s;
    logic               rx_pop_s;
    logic               rx_full_s;
    logic               rx_empty_s;
    logic [CNT_W-1:0]   rx_count_s;

    logic               start_ok_s;

    // Both the flag and the count must agree before a slot is trusted.
    assign tx_ready   = !tx_full_s && (tx_count_s != CNT_W'(FIFO_DEPTH));
    assign tx_push_s  = tx_valid && tx_ready;
    assign tx_wr_s    = pack_entry(tx_last, tx_data);
    assign start_ok_s = !tx_empty_s && !rx_full_s && (rx_count_s <= CNT_W'(FIFO_DEPTH - 1));
    assign tx_pop_s   = (state_r == IDLE) && start_ok_s;

    assign rx_push_s  = (state_r == CAPTURE);
    assign rx_wr_s    = pack_entry(cur_last_r, drv_data_out);
    assign rx_valid   = !rx_empty_s;
    assign rx_pop_s   = rx_valid && rx_ready;
    assign rx_data    = rx_rd_s[BYTE_W-1:0];
    assign rx_last    = rx_rd_s[BYTE_W];

    sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (tx_push_s),
        .wr_data (tx_wr_s),
        .pop     (tx_pop_s),
        .rd_data (tx_rd_s),
        .full    (tx_full_s),
        .empty   (tx_empty_s),
        .count   (tx_count_s)
    );

    sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (rx_push_s),
        .wr_data (rx_wr_s),
        .pop     (rx_pop_s),
        .rd_data (rx_rd_s),
        .full    (rx_full_s),
        .empty   (rx_empty_s),
        .count   (rx_count_s)
    );

    // Byte sequencing FSM with start-timeout watchdog and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cur_last_r  <= 1'b0;
            to_cnt_r    <= {TO_W{1'b0}};
            drv_data_in <= {BYTE_W{1'b0}};
            drv_start   <= 1'b0;
            txn_active  <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            drv_start <= 1'b0;
            if (err_clr) begin
                err_timeout <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (start_ok_s) begin
                        drv_data_in <= tx_rd_s[BYTE_W-1:0];
                        cur_last_r  <= tx_rd_s[BYTE_W];
                        txn_active  <= 1'b1;
                        drv_start   <= 1'b1;
                        state_r     <= START;
                    end
                end
                START: begin
                    to_cnt_r <= {TO_W{1'b0}};
                    state_r  <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (drv_busy) begin
                        state_r <= WAIT_DONE;
                    end else if (to_cnt_r == TO_W'(START_TIMEOUT - 1)) begin
                        // Byte is dropped; a new timeout beats a same-cycle clear.
                        err_timeout <= 1'b1;
                        if (cur_last_r) begin
                            txn_active <= 1'b0;
                        end
                        state_r <= IDLE;
                    end else begin
                        to_cnt_r <= to_cnt_r + TO_W'(1'b1);
                    end
                end
                WAIT_DONE: begin
                    if (!drv_busy) begin
                        state_r <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (cur_last_r) begin
                        txn_active <= 1'b0;
                    end
                    state_r <= IDLE;
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule
